// File: rtl/reg_file_sb.sv
// Register file with per-register pending-write scoreboard for decode hazard detection.
// Reads are combinational (optional write bypass); writes, issues and busy_count update on the rising edge.
module reg_file_sb #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NREAD*AW-1:0]    rd_addr,
  output logic [NREAD*WIDTH-1:0] rd_data,
  output logic [NREAD-1:0]       rd_busy,
  input  logic                   wr_en,
  input  logic [AW-1:0]          wr_addr,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   issue_en,
  input  logic [AW-1:0]          issue_addr,
  output logic [AW:0]            busy_count
);

  localparam logic [AW:0] CNT_ONE = 1;

  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_nxt;
  logic [AW:0]      cnt_nxt;
  logic             wr_ok;
  logic             iss_ok;
  logic             cnt_set;
  logic             cnt_clr;

  // Register 0 swallows writes and issues entirely when hard-wired to zero.
  assign wr_ok  = wr_en    && !((ZERO_REG != 0) && (wr_addr    == '0));
  assign iss_ok = issue_en && !((ZERO_REG != 0) && (issue_addr == '0));

  // Issue is applied after write so a same-address issue leaves the register pending.
  always_comb begin
    busy_nxt = busy;
    if (wr_ok)  busy_nxt[wr_addr]    = 1'b0;
    if (iss_ok) busy_nxt[issue_addr] = 1'b1;
  end

  assign cnt_set = iss_ok && !busy[issue_addr];
  assign cnt_clr = wr_ok && busy[wr_addr] && !(iss_ok && (issue_addr == wr_addr));

  always_comb begin
    cnt_nxt = busy_count;
    if (cnt_set && !cnt_clr)      cnt_nxt = busy_count + CNT_ONE;
    else if (cnt_clr && !cnt_set) cnt_nxt = busy_count - CNT_ONE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int j = 0; j < DEPTH; j++) regs[j] <= '0;
      busy       <= '0;
      busy_count <= '0;
    end else begin
      if (wr_ok) regs[wr_addr] <= wr_data;
      busy       <= busy_nxt;
      busy_count <= cnt_nxt;
    end
  end

  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [AW-1:0] addr;
    logic          is_zero;
    logic          hit;

    assign addr    = rd_addr[i*AW +: AW];
    assign is_zero = (ZERO_REG != 0) && (addr == '0);
    assign hit     = (BYPASS != 0) && wr_ok && (wr_addr == addr);

    // Outputs are forced low while reset is held so a live bypass cannot leak through.
    assign rd_data[i*WIDTH +: WIDTH] = (!reset_n || is_zero) ? '0 :
                                       hit ? wr_data : regs[addr];
    assign rd_busy[i] = (!reset_n || is_zero) ? 1'b0 :
                        hit ? (iss_ok && (issue_addr == addr)) : busy[addr];
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: vector table with expected-result queue, plus reset and wide/narrow corner sequences.
module tb_reg_file_sb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic [9:0]  rd_addr;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        issue_en;
  logic [4:0]  issue_addr;
  logic [63:0] rd_data, rd_data_nb;
  logic [1:0]  rd_busy, rd_busy_nb;
  logic [5:0]  busy_count, busy_count_nb;

  logic [11:0] s_rd_addr;
  logic        s_wr_en;
  logic [2:0]  s_wr_addr;
  logic [15:0] s_wr_data;
  logic        s_issue_en;
  logic [2:0]  s_issue_addr;
  logic [63:0] s_rd_data;
  logic [3:0]  s_rd_busy;
  logic [3:0]  s_busy_count;

  reg_file_sb #(.WIDTH(32), .DEPTH(32), .NREAD(2), .ZERO_REG(1), .BYPASS(1)) u_dut (
    .clk(clk), .reset_n(reset_n), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .issue_en(issue_en),
    .issue_addr(issue_addr), .busy_count(busy_count));

  reg_file_sb #(.WIDTH(32), .DEPTH(32), .NREAD(2), .ZERO_REG(0), .BYPASS(0)) u_nb (
    .clk(clk), .reset_n(reset_n), .rd_addr(rd_addr), .rd_data(rd_data_nb), .rd_busy(rd_busy_nb),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .issue_en(issue_en),
    .issue_addr(issue_addr), .busy_count(busy_count_nb));

  reg_file_sb #(.WIDTH(16), .DEPTH(8), .NREAD(4), .ZERO_REG(0), .BYPASS(1)) u_small (
    .clk(clk), .reset_n(reset_n), .rd_addr(s_rd_addr), .rd_data(s_rd_data), .rd_busy(s_rd_busy),
    .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data), .issue_en(s_issue_en),
    .issue_addr(s_issue_addr), .busy_count(s_busy_count));

  typedef struct {
    logic        ie;
    logic [4:0]  ia;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] d0;
    logic [31:0] d1;
    logic        b0;
    logic        b1;
    logic [5:0]  cnt;
    logic [31:0] nb_d0;
  } vec_t;

  typedef struct {
    logic [31:0] d0;
    logic [31:0] d1;
    logic        b0;
    logic        b1;
    logic [5:0]  cnt;
    logic [31:0] nb_d0;
  } exp_t;

  localparam int NV = 17;
  vec_t vt [NV];
  exp_t exp_q [$];
  exp_t e;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  initial begin
    // Expected values are the outputs seen before the edge that commits the vector.
    //          ie    ia     we    wa     wd             ra0    ra1    d0             d1             b0    b1    cnt   nb_d0
    vt[0]  = '{1'b1, 5'd5,  1'b0, 5'd0,  32'h0,         5'd5,  5'd0,  32'h0,         32'h0,         1'b0, 1'b0, 6'd0, 32'h0};
    vt[1]  = '{1'b0, 5'd0,  1'b0, 5'd0,  32'h0,         5'd5,  5'd5,  32'h0,         32'h0,         1'b1, 1'b1, 6'd1, 32'h0};
    vt[2]  = '{1'b0, 5'd0,  1'b1, 5'd5,  32'hDEADBEEF,  5'd5,  5'd3,  32'hDEADBEEF,  32'h0,         1'b0, 1'b0, 6'd1, 32'h0};
    vt[3]  = '{1'b1, 5'd7,  1'b1, 5'd7,  32'h12345678,  5'd5,  5'd7,  32'hDEADBEEF,  32'h12345678,  1'b0, 1'b1, 6'd0, 32'hDEADBEEF};
    vt[4]  = '{1'b0, 5'd0,  1'b0, 5'd0,  32'h0,         5'd7,  5'd5,  32'h12345678,  32'hDEADBEEF,  1'b1, 1'b0, 6'd1, 32'h12345678};
    vt[5]  = '{1'b1, 5'd9,  1'b0, 5'd0,  32'h0,         5'd9,  5'd7,  32'h0,         32'h12345678,  1'b0, 1'b1, 6'd1, 32'h0};
    vt[6]  = '{1'b1, 5'd3,  1'b1, 5'd9,  32'hCAFEF00D,  5'd3,  5'd9,  32'h0,         32'hCAFEF00D,  1'b0, 1'b0, 6'd2, 32'h0};
    vt[7]  = '{1'b0, 5'd0,  1'b0, 5'd0,  32'h0,         5'd3,  5'd9,  32'h0,         32'hCAFEF00D,  1'b1, 1'b0, 6'd2, 32'h0};
    vt[8]  = '{1'b1, 5'd7,  1'b0, 5'd0,  32'h0,         5'd7,  5'd3,  32'h12345678,  32'h0,         1'b1, 1'b1, 6'd2, 32'h12345678};
    vt[9]  = '{1'b0, 5'd0,  1'b1, 5'd4,  32'hA5A5A5A5,  5'd4,  5'd4,  32'hA5A5A5A5,  32'hA5A5A5A5,  1'b0, 1'b0, 6'd2, 32'h0};
    vt[10] = '{1'b1, 5'd0,  1'b1, 5'd0,  32'hFFFFFFFF,  5'd0,  5'd4,  32'h0,         32'hA5A5A5A5,  1'b0, 1'b0, 6'd2, 32'h0};
    vt[11] = '{1'b0, 5'd0,  1'b0, 5'd0,  32'h0,         5'd0,  5'd7,  32'h0,         32'h12345678,  1'b0, 1'b1, 6'd2, 32'hFFFFFFFF};
    vt[12] = '{1'b1, 5'd12, 1'b1, 5'd7,  32'h11112222,  5'd7,  5'd12, 32'h11112222,  32'h0,         1'b0, 1'b0, 6'd2, 32'h12345678};
    vt[13] = '{1'b0, 5'd0,  1'b0, 5'd0,  32'h0,         5'd7,  5'd12, 32'h11112222,  32'h0,         1'b0, 1'b1, 6'd2, 32'h11112222};
    vt[14] = '{1'b0, 5'd0,  1'b1, 5'd3,  32'h00000033,  5'd3,  5'd12, 32'h00000033,  32'h0,         1'b0, 1'b1, 6'd2, 32'h0};
    vt[15] = '{1'b0, 5'd0,  1'b1, 5'd12, 32'h0000C0C0,  5'd3,  5'd12, 32'h00000033,  32'h0000C0C0,  1'b0, 1'b0, 6'd1, 32'h00000033};
    vt[16] = '{1'b0, 5'd0,  1'b0, 5'd0,  32'h0,         5'd12, 5'd31, 32'h0000C0C0,  32'h0,         1'b0, 1'b0, 6'd0, 32'h0000C0C0};

    reset_n = 1'b0;
    rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; issue_en = 1'b0; issue_addr = '0;
    s_rd_addr = '0; s_wr_en = 1'b0; s_wr_addr = '0; s_wr_data = '0; s_issue_en = 1'b0; s_issue_addr = '0;

    repeat (2) @(negedge clk);
    #1;
    chk("reset_count", {58'd0, busy_count}, 64'd0);
    chk("reset_count_nb", {58'd0, busy_count_nb}, 64'd0);
    chk("reset_count_small", {60'd0, s_busy_count}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // After reset every register reads zero and idle.
    for (int a = 0; a < 16; a++) begin
      @(negedge clk);
      rd_addr = {5'(a + 16), 5'(a)};
      #1;
      chk("reset_sweep_data", rd_data, 64'd0);
      chk("reset_sweep_busy", {62'd0, rd_busy}, 64'd0);
    end

    for (int k = 0; k < NV; k++) begin
      @(negedge clk);
      issue_en = vt[k].ie; issue_addr = vt[k].ia;
      wr_en = vt[k].we; wr_addr = vt[k].wa; wr_data = vt[k].wd;
      rd_addr = {vt[k].ra1, vt[k].ra0};
      exp_q.push_back('{vt[k].d0, vt[k].d1, vt[k].b0, vt[k].b1, vt[k].cnt, vt[k].nb_d0});
      #1;
      if (exp_q.size() == 0) begin
        chk("scoreboard_empty", 64'd0, 64'd1);
      end else begin
        e = exp_q.pop_front();
        chk($sformatf("v%0d_d0", k), {32'd0, rd_data[31:0]}, {32'd0, e.d0});
        chk($sformatf("v%0d_d1", k), {32'd0, rd_data[63:32]}, {32'd0, e.d1});
        chk($sformatf("v%0d_busy", k), {62'd0, rd_busy}, {62'd0, e.b1, e.b0});
        chk($sformatf("v%0d_count", k), {58'd0, busy_count}, {58'd0, e.cnt});
        chk($sformatf("v%0d_nb_d0", k), {32'd0, rd_data_nb[31:0]}, {32'd0, e.nb_d0});
      end
    end

    // Asynchronous reset mid-operation: outputs clear at once and the pending write is lost.
    @(negedge clk);
    rd_addr = {5'd9, 5'd5};
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h77; issue_en = 1'b1; issue_addr = 5'd5;
    reset_n = 1'b0;
    #1;
    chk("arst_data", rd_data, 64'd0);
    chk("arst_busy", {62'd0, rd_busy}, 64'd0);
    chk("arst_count", {58'd0, busy_count}, 64'd0);
    chk("arst_data_nb", rd_data_nb, 64'd0);
    chk("arst_count_nb", {58'd0, busy_count_nb}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    issue_en = 1'b0;
    wr_addr = 5'd6; wr_data = 32'h66;
    rd_addr = {5'd6, 5'd5};
    #1;
    chk("release_bypass", rd_data, {32'h66, 32'h0});
    @(negedge clk);
    wr_en = 1'b0;
    #1;
    chk("first_edge_write_nb", rd_data_nb, {32'h66, 32'h0});
    chk("first_edge_count", {58'd0, busy_count}, 64'd0);

    // Narrow, deep-read instance: fill the scoreboard, read on four ports, drain.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      s_issue_en = 1'b1; s_issue_addr = 3'(i);
      #1;
      chk($sformatf("small_fill_count%0d", i), {60'd0, s_busy_count}, 64'(i));
    end
    @(negedge clk);
    s_issue_en = 1'b0;
    s_rd_addr = {3'd6, 3'd5, 3'd3, 3'd1};
    #1;
    chk("small_full_count", {60'd0, s_busy_count}, 64'd8);
    chk("small_full_busy", {60'd0, s_rd_busy}, 64'hF);
    chk("small_full_data", s_rd_data, 64'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      s_wr_en = 1'b1; s_wr_addr = 3'(i); s_wr_data = 16'h1000 + 16'(i);
      s_rd_addr = {3'(i), 3'(i), 3'(i), 3'(i)};
      #1;
      chk($sformatf("small_drain_count%0d", i), {60'd0, s_busy_count}, 64'(8 - i));
      chk($sformatf("small_drain_bypass%0d", i), {48'd0, s_rd_data[15:0]}, 64'(16'h1000 + 16'(i)));
    end
    @(negedge clk);
    s_wr_en = 1'b0;
    s_rd_addr = {3'd7, 3'd5, 3'd2, 3'd0};
    #1;
    chk("small_empty_count", {60'd0, s_busy_count}, 64'd0);
    chk("small_empty_busy", {60'd0, s_rd_busy}, 64'd0);
    chk("small_empty_data", s_rd_data, 64'h1007_1005_1002_1000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
